// File: rtl/first_maxpool_pkg.sv
// Shared types and helpers for the first max-pool read/reduce stage.
package first_maxpool_pkg;

  localparam int DEF_D_WIDTH    = 15;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  // Signed maximum; on a tie the first operand (the accumulator) wins.
  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_out_fifo2.sv
// Two-entry result FIFO carrying a pooled value plus its end-of-run marker.
module maxpool_out_fifo2 #(
  parameter int D_WIDTH = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic               push_last,
  input  logic               pop,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [D_WIDTH-1:0] head_data,
  output logic               head_last
);

  logic [D_WIDTH-1:0] data_reg [2];
  logic               last_reg [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg[0] <= '0;
      data_reg[1] <= '0;
      last_reg[0] <= 1'b0;
      last_reg[1] <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
    end else begin
      if (push) begin
        data_reg[wr_ptr_reg] <= push_data;
        last_reg[wr_ptr_reg] <= push_last;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 2'd1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 2'd1;
      end
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != 2'd0);
  assign head_data  = data_reg[rd_ptr_reg];
  assign head_last  = last_reg[rd_ptr_reg];

endmodule

// File: rtl/first_maxpool_rd.sv
// Walks the feature buffer, reduces non-overlapping POOL windows to their
// signed maximum and streams the results out on a valid/ready port.
module first_maxpool_rd
  import first_maxpool_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int D_WIDTH    = DEF_D_WIDTH,
  parameter int LEN        = 128,
  parameter int POOL       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  en_r,
  output logic [ADDR_WIDTH-1:0] addr_r,
  input  logic [D_WIDTH-1:0]    dat_read,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [D_WIDTH-1:0]    m_data,
  output logic                  m_last
);

  localparam int N_OUT = LEN / POOL;
  localparam int WIN_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_OUT * POOL - 1);

  if (POOL < 2 || LEN < POOL || LEN > 2 ** ADDR_WIDTH) begin : g_param_err
    $error("first_maxpool_rd: POOL must be >= 2 and POOL <= LEN <= 2**ADDR_WIDTH");
  end

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_cnt_reg;
  logic [ADDR_WIDTH-1:0]  addr_last_reg;
  logic [WIN_W-1:0]       win_cnt_reg;
  logic                   rd_valid_reg;
  logic                   rd_first_reg;
  logic                   rd_wlast_reg;
  logic                   rd_final_reg;
  logic signed [D_WIDTH-1:0] acc_reg;

  logic                   win_last;
  logic                   final_issue;
  logic                   credit_ok;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [D_WIDTH-1:0]     pool_max;
  logic [1:0]             fifo_count;
  logic                   head_valid;

  assign win_last    = (win_cnt_reg == WIN_W'(POOL - 1));
  assign final_issue = (addr_cnt_reg == LAST_ADDR);
  // Reserve a FIFO slot for every window-last read still in flight; a pop in
  // the same cycle earns no credit, so the FIFO can never overflow.
  assign credit_ok   = (fifo_count + 2'(rd_valid_reg && rd_wlast_reg)) < 2'd2;
  assign issue       = (state_reg == READ) && (!win_last || credit_ok);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    if (issue && final_issue) state_next = DRAIN;
      DRAIN:   if (!rd_valid_reg && fifo_count == 2'd0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      addr_cnt_reg  <= '0;
      addr_last_reg <= '0;
      win_cnt_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      rd_first_reg  <= 1'b0;
      rd_wlast_reg  <= 1'b0;
      rd_final_reg  <= 1'b0;
      acc_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        addr_cnt_reg <= '0;
        win_cnt_reg  <= '0;
      end else if (issue) begin
        addr_last_reg <= addr_cnt_reg;
        if (!final_issue) addr_cnt_reg <= addr_cnt_reg + ADDR_WIDTH'(1);
        win_cnt_reg <= win_last ? '0 : win_cnt_reg + WIN_W'(1);
      end
      rd_valid_reg <= issue;
      rd_first_reg <= (win_cnt_reg == '0);
      rd_wlast_reg <= win_last;
      rd_final_reg <= final_issue;
      if (rd_valid_reg && rd_first_reg) begin
        acc_reg <= $signed(dat_read);
      end else if (rd_valid_reg && !rd_wlast_reg) begin
        acc_reg <= D_WIDTH'(smax(32'(acc_reg), 32'($signed(dat_read))));
      end
    end
  end

  // The window-last element bypasses the accumulator straight into the FIFO.
  assign pool_max = D_WIDTH'(smax(32'(acc_reg), 32'($signed(dat_read))));
  assign push     = rd_valid_reg && rd_wlast_reg;
  assign pop      = head_valid && m_ready;

  maxpool_out_fifo2 #(
    .D_WIDTH(D_WIDTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pool_max),
    .push_last (rd_final_reg),
    .pop       (pop),
    .count     (fifo_count),
    .head_valid(head_valid),
    .head_data (m_data),
    .head_last (m_last)
  );

  assign m_valid = head_valid;
  assign en_r    = issue;
  assign addr_r  = issue ? addr_cnt_reg : addr_last_reg;
  assign busy    = (state_reg == READ) || (state_reg == DRAIN);
  assign done    = (state_reg == FIN);

endmodule

// File: tb/tb_first_maxpool_rd.sv
// Bench for first_maxpool_rd: three instances (LEN 8, 128, 7) against a window-max model.
module tb_first_maxpool_rd;

  localparam int NI   = 3;
  localparam int POOL = 2;
  localparam int LENS [NI] = '{8, 128, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [NI];
  logic        start    [NI];
  logic        busy     [NI];
  logic        done     [NI];
  logic        en_r     [NI];
  logic [9:0]  addr_r   [NI];
  logic [14:0] dat_read [NI];
  logic        m_valid  [NI];
  logic        m_ready  [NI];
  logic [14:0] m_data   [NI];
  logic        m_last   [NI];
  logic [14:0] ram      [NI][128];

  first_maxpool_rd #(.ADDR_WIDTH(10), .D_WIDTH(15), .LEN(8), .POOL(2)) u_len8 (
    .clk(clk), .reset(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .en_r(en_r[0]), .addr_r(addr_r[0]), .dat_read(dat_read[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]));

  first_maxpool_rd #(.ADDR_WIDTH(10), .D_WIDTH(15), .LEN(128), .POOL(2)) u_len128 (
    .clk(clk), .reset(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .en_r(en_r[1]), .addr_r(addr_r[1]), .dat_read(dat_read[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]));

  first_maxpool_rd #(.ADDR_WIDTH(10), .D_WIDTH(15), .LEN(7), .POOL(2)) u_len7 (
    .clk(clk), .reset(rst_n[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .en_r(en_r[2]), .addr_r(addr_r[2]), .dat_read(dat_read[2]), .m_valid(m_valid[2]),
    .m_ready(m_ready[2]), .m_data(m_data[2]), .m_last(m_last[2]));

  // RAM model with one cycle of read latency
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (en_r[i]) dat_read[i] <= ram[i][addr_r[i][6:0]];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int exp_q   [NI][$];
  int got_q   [NI][$];
  int pop_cyc [NI][$];
  bit run_active [NI];
  bit rst_seen   [NI];
  bit hold_v     [NI];
  logic [14:0] hold_d [NI];
  logic        hold_l [NI];
  int first_en [NI], last_en [NI], first_valid [NI], en_cnt [NI], busy_cnt [NI];
  int done_cyc [NI], done_cnt [NI], addr6_cnt [NI], gap_bad [NI];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_stats(input int i);
    first_en[i] = -1; last_en[i] = -1; first_valid[i] = -1;
    en_cnt[i] = 0; busy_cnt[i] = 0; done_cyc[i] = -1;
    addr6_cnt[i] = 0; gap_bad[i] = 0;
    got_q[i].delete(); pop_cyc[i].delete();
  endtask

  // Expected results: max over each complete window, tail elements ignored.
  task automatic fill_model(input int i);
    exp_q[i].delete();
    for (int w = 0; w < LENS[i] / POOL; w++) begin
      int m;
      m = $signed(ram[i][w * POOL]);
      for (int e = 1; e < POOL; e++) begin
        int v;
        v = $signed(ram[i][w * POOL + e]);
        if (v > m) m = v;
      end
      exp_q[i].push_back(m);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      if (rst_seen[i]) begin
        chk("rst_ctrl_outputs", int'({busy[i], done[i], en_r[i], m_valid[i], m_last[i]}), 0);
        chk("rst_addr_r", int'(addr_r[i]), 0);
        chk("rst_m_data", int'(m_data[i]), 0);
        rst_seen[i] = 1'b0;
      end
      if (!rst_n[i]) begin
        rst_seen[i] = 1'b1;
        exp_q[i].delete();
        run_active[i] = 1'b0;
        hold_v[i] = 1'b0;
        continue;
      end
      if (busy[i]) busy_cnt[i]++;
      if (en_r[i]) begin
        chk("addr_sequence", int'(addr_r[i]), en_cnt[i]);
        if (addr_r[i] == 10'd6) addr6_cnt[i]++;
        if (first_en[i] < 0) first_en[i] = cyc;
        last_en[i] = cyc;
        en_cnt[i]++;
      end
      if (m_valid[i] && first_valid[i] < 0) first_valid[i] = cyc;
      if (hold_v[i]) begin
        chk("m_data_stable", int'(m_data[i]), int'(hold_d[i]));
        chk("m_last_stable", int'(m_last[i]), int'(hold_l[i]));
      end
      if (m_valid[i] && m_ready[i]) begin
        chk("model_has_result", int'(exp_q[i].size() != 0), 1);
        if (exp_q[i].size() != 0) begin
          int e;
          e = exp_q[i].pop_front();
          chk("m_data", int'($signed(m_data[i])), e);
          chk("m_last", int'(m_last[i]), int'(exp_q[i].size() == 0));
        end
        if (pop_cyc[i].size() != 0 && cyc - pop_cyc[i][$] != POOL) gap_bad[i]++;
        pop_cyc[i].push_back(cyc);
        got_q[i].push_back(int'($signed(m_data[i])));
        $display("inst%0d cycle %0d result #%0d = %0d last=%0b",
                 i, cyc, got_q[i].size() - 1, $signed(m_data[i]), m_last[i]);
      end
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        chk("done_all_results_out", exp_q[i].size(), 0);
        run_active[i] = 1'b0;
      end
      hold_v[i] = m_valid[i] && !m_ready[i];
      hold_d[i] = m_data[i];
      hold_l[i] = m_last[i];
      if (start[i] && !run_active[i]) begin
        run_active[i] = 1'b1;
        clear_stats(i);
        fill_model(i);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_done(input int i, input int budget, input bit rand_ready);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt[i];
    while (done_cnt[i] == d0 && n < budget) begin
      if (rand_ready) m_ready[i] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("done_within_budget", int'(done_cnt[i] != d0), 1);
  endtask

  task automatic pulse_start(input int i, output int t0);
    start[i] = 1'b1;
    t0 = cyc;
    tick();
    start[i] = 1'b0;
  endtask

  int t0;
  int b0;
  int n;
  int base8 [8] = '{1, 5, -3, -7, 4, 4, 0, -1};
  int ext8  [8] = '{'h4000, 'h3FFF, 'h7FFF, 'h7FFF, 'h4000, 'h4000, 'h7FFF, 'h0000};
  int len7  [7] = '{3, -2, 9, 9, -5, -6, 100};
  int exp_base [4] = '{5, -3, 4, 0};

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; m_ready[i] = 1'b0;
      run_active[i] = 1'b0; rst_seen[i] = 1'b0; hold_v[i] = 1'b0; done_cnt[i] = 0;
      clear_stats(i);
      for (int k = 0; k < 128; k++) ram[i][k] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    tick();

    // 1: basic run, full-rate consumer
    for (int k = 0; k < 8; k++) ram[0][k] = 15'(base8[k]);
    m_ready[0] = 1'b1;
    pulse_start(0, t0);
    run_until_done(0, 100, 1'b0);
    chk("t1_first_en_cycle", first_en[0] - t0, 1);
    chk("t1_first_valid_cycle", first_valid[0] - t0, 4);
    chk("t1_result_count", got_q[0].size(), 4);
    for (int k = 0; k < 4 && k < got_q[0].size(); k++) chk("t1_result_literal", got_q[0][k], exp_base[k]);
    chk("t1_done_after_last_pop", done_cyc[0] - pop_cyc[0][$], 2);
    chk("t1_busy_cycles", busy_cnt[0], 11);
    chk("t1_reads_issued", en_cnt[0], 8);
    tick();

    // 2: consumer stalled for 20 cycles after start
    m_ready[0] = 1'b0;
    pulse_start(0, t0);
    repeat (19) tick();
    chk("t2_reads_before_stall", en_cnt[0], 5);
    chk("t2_last_read_cycle", last_en[0] - t0, 5);
    chk("t2_m_valid_held", int'(m_valid[0]), 1);
    chk("t2_m_data_held", int'($signed(m_data[0])), 5);
    chk("t2_nothing_popped", got_q[0].size(), 0);
    m_ready[0] = 1'b1;
    run_until_done(0, 100, 1'b0);
    chk("t2_result_count", got_q[0].size(), 4);
    for (int k = 0; k < 4 && k < got_q[0].size(); k++) chk("t2_result_literal", got_q[0][k], exp_base[k]);
    tick();

    // 4: signed extremes in 15 bits
    for (int k = 0; k < 8; k++) ram[0][k] = 15'(ext8[k]);
    pulse_start(0, t0);
    run_until_done(0, 100, 1'b0);
    chk("t4_result_count", got_q[0].size(), 4);
    if (got_q[0].size() == 4) begin
      chk("t4_pos_vs_neg_hex", got_q[0][0] & 'h7FFF, 'h3FFF);
      chk("t4_minus1_pair_hex", got_q[0][1] & 'h7FFF, 'h7FFF);
      chk("t4_most_negative_tie", got_q[0][2], -16384);
      chk("t4_minus1_vs_zero", got_q[0][3], 0);
    end
    tick();

    // 3: long ramp, full throughput
    for (int k = 0; k < 128; k++) ram[1][k] = 15'(k * 200 - 12000);
    m_ready[1] = 1'b1;
    pulse_start(1, t0);
    run_until_done(1, 400, 1'b0);
    chk("t3_result_count", got_q[1].size(), 64);
    chk("t3_busy_cycles", busy_cnt[1], 131);
    chk("t3_result_spacing_errors", gap_bad[1], 0);
    chk("t3_reads_issued", en_cnt[1], 128);
    if (got_q[1].size() == 64) begin
      chk("t3_first_result", got_q[1][0], -11800);
      chk("t3_last_result", got_q[1][63], 13400);
    end
    tick();

    // 5: random back-pressure, reset after 10 results, restart
    for (int k = 0; k < 128; k++) ram[1][k] = 15'($urandom);
    pulse_start(1, t0);
    n = 0;
    while (got_q[1].size() < 10 && n < 1000) begin
      m_ready[1] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("t5_ten_results_within_budget", int'(got_q[1].size() >= 10), 1);
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    tick();
    chk("t5_fifo_empty_after_reset", int'(m_valid[1]), 0);
    pulse_start(1, t0);
    run_until_done(1, 2000, 1'b1);
    chk("t5_result_count_after_restart", got_q[1].size(), 64);
    chk("t5_restart_from_index0", first_en[1] - t0, 1);
    m_ready[1] = 1'b1;
    tick();

    // 6: odd length with a second start while busy
    for (int k = 0; k < 7; k++) ram[2][k] = 15'(len7[k]);
    m_ready[2] = 1'b1;
    pulse_start(2, t0);
    tick();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    run_until_done(2, 100, 1'b0);
    chk("t6_result_count", got_q[2].size(), 3);
    if (got_q[2].size() == 3) begin
      chk("t6_result0", got_q[2][0], 3);
      chk("t6_result1", got_q[2][1], 9);
      chk("t6_result2", got_q[2][2], -5);
    end
    chk("t6_reads_issued", en_cnt[2], 6);
    chk("t6_tail_addr6_reads", addr6_cnt[2], 0);
    b0 = busy_cnt[2];
    repeat (10) tick();
    chk("t6_no_second_run", busy_cnt[2] - b0, 0);
    chk("t6_single_done", done_cnt[2], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
